// File: rtl/riscv_mem_arbiter_model.sv
// Shared line-organised backing memory for N_CH cache-refill channels behind a round-robin arbiter.
// Ready pulses LAT+1 cycles after the request is sampled; requests from other channels wait while their level is held.
module riscv_mem_arbiter_model #(
  parameter int DATA_WIDTH = 128,
  parameter int N_CH       = 2,
  parameter int MEM_DEPTH  = 1024,
  parameter int S_ADDR     = $clog2(MEM_DEPTH),
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 4,
  parameter int CH_W       = (N_CH > 1 ? $clog2(N_CH) : 1)
) (
  input  logic                         i_riscv_clk,
  input  logic                         i_riscv_rst,
  input  logic [N_CH-1:0]              i_ch_rden,
  input  logic [N_CH-1:0]              i_ch_wren,
  input  logic [N_CH*S_ADDR-1:0]       i_ch_addr,
  input  logic [N_CH*DATA_WIDTH-1:0]   i_ch_wdata,
  output logic [N_CH*DATA_WIDTH-1:0]   o_ch_rdata,
  output logic [N_CH-1:0]              o_ch_ready,
  output logic                         o_busy,
  output logic [CH_W-1:0]              o_grant_ch
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [CH_W-1:0]              ptr_q, ptr_d;
  logic                         wr_q, wr_d;
  logic [S_ADDR-1:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [N_CH-1:0]              ready_q, ready_d;
  logic [N_CH*DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0]        mem_q [MEM_DEPTH];
  logic                         mem_we;
  logic                         addr_ok;

  logic [N_CH-1:0]              req;
  logic                         gnt_vld;
  logic [CH_W-1:0]              gnt_ch;

  assign req     = i_ch_rden | i_ch_wren;
  assign addr_ok = (int'(addr_q) < MEM_DEPTH);

  // Search upward from the channel after the last winner so every held request is reached within N_CH grants.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(ptr_q) + i) % N_CH;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = '0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          ch_d    = gnt_ch;
          ptr_d   = gnt_ch;
          // A simultaneous read and write on one channel is served as the write.
          wr_d    = i_ch_wren[gnt_ch];
          addr_d  = i_ch_addr[gnt_ch*S_ADDR +: S_ADDR];
          wdata_d = i_ch_wdata[gnt_ch*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = i_ch_wren[gnt_ch] ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          ready_d[ch_q] = 1'b1;
          state_d       = ST_GAP;
          if (wr_q) begin
            mem_we = addr_ok;
          end else begin
            rdata_d[ch_q*DATA_WIDTH +: DATA_WIDTH] = addr_ok ? mem_q[addr_q] : '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_riscv_clk or negedge i_riscv_rst) begin
    if (!i_riscv_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= CH_W'(N_CH - 1);
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; the write enable is already gated by the reset state machine.
  always_ff @(posedge i_riscv_clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign o_ch_rdata = rdata_q;
  assign o_ch_ready = ready_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_grant_ch = ch_q;

endmodule
